// File: rtl/d_in_debounce_sync_if.sv
// rtl/d_in_debounce_sync_if.sv - raw input and conditioned outputs of the debouncer
interface d_in_debounce_sync_if;
   logic din;
   logic d_out;
   logic rise;
   logic fall;
   logic busy;

   modport master (output din, input d_out, rise, fall, busy);
   modport slave  (input din, output d_out, rise, fall, busy);
endinterface

// File: rtl/d_in_debounce_sync.sv
// rtl/d_in_debounce_sync.sv - synchronise and debounce a raw level, with rise/fall pulses
module d_in_debounce_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 4,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   d_in_debounce_sync_if.slave   io
);

   typedef enum logic [1:0] {
      ST_LOW   = 2'd0,
      CHK_HIGH = 2'd1,
      ST_HIGH  = 2'd2,
      CHK_LOW  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   d_out_q, d_out_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   busy_q, busy_d;
   logic                   s;

   // Plain shift chain: nothing may sit between metastability stages.
   assign sync_d = {sync_q[SYNC_STAGES-2:0], io.din};
   assign s      = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         state_q <= ST_LOW;
         cnt_q   <= '0;
         d_out_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         d_out_q <= d_out_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      d_out_d = d_out_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         ST_LOW: begin
            if (s) begin
               state_d = CHK_HIGH;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         CHK_HIGH: begin
            if (!s) begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
               d_out_d = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         ST_HIGH: begin
            if (!s) begin
               state_d = CHK_LOW;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         CHK_LOW: begin
            if (s) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_LOW;
               cnt_d   = '0;
               d_out_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_LOW;
            cnt_d   = '0;
            d_out_d = 1'b0;
         end
      endcase
      busy_d = (state_d == CHK_HIGH) || (state_d == CHK_LOW);
   end

   assign io.d_out = d_out_q;
   assign io.rise  = rise_q;
   assign io.fall  = fall_q;
   assign io.busy  = busy_q;

endmodule
